fp_norm_ctrl: RTL and testbench

Multi-cycle normalization sequencer for the single-precision add/sub datapath. It accepts a raw 25-bit post-add mantissa (carry bit plus 24-bit significand) with its exponent and sign, and drives the shared LOPD_24bit leading-one detector. It then applies the resulting left shift (or a one-bit right shift on carry) with exponent correction and overflow/subnormal clamping, and hands a normalized result to the rounding stage over a valid/ready handshake.

---
 rtl/fp_norm_pkg.sv | 11 +
 rtl/LOPD_24bit.sv | 18 +
 rtl/fp_norm_ctrl.sv | 136 +++++++++++++
 tb/tb_fp_norm_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared types and widths for the single-precision normalization sequencer.
package fp_norm_pkg;
   typedef enum logic [1:0] {S_IDLE, S_DETECT, S_SHIFT, S_OUT} state_t;

   localparam int MANT_W = 24;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;

   localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
   localparam logic [4:0]       LZC_ZERO = 5'd31;
endpackage

// File: rtl/LOPD_24bit.sv
// Leading-one position detector: counts leading zeros of a 24-bit significand,
// reporting LZC_ZERO and a zero flag when no bit is set.
module LOPD_24bit
   import fp_norm_pkg::*;
(
   input  logic [MANT_W-1:0] a,
   output logic [4:0]        lz,
   output logic              zero
);
   always_comb begin
      lz   = LZC_ZERO;
      zero = (a == '0);
      // Ascending scan: the highest set bit is the last one to write lz.
      for (int i = 0; i < MANT_W; i++) begin
         if (a[i]) lz = 5'(MANT_W - 1 - i);
      end
   end
endmodule

// File: rtl/fp_norm_ctrl.sv
// Normalization sequencer: capture, leading-one detect, shift/clamp, then hold
// the normalized result for the rounding stage on a valid/ready handshake.
module fp_norm_ctrl
   import fp_norm_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [MANT_W:0]   i_mant,
   input  logic [EXP_W-1:0]  i_exp,
   input  logic              i_sign,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [FRAC_W-1:0] o_frac,
   output logic [EXP_W-1:0]  o_exp,
   output logic              o_sign,
   output logic              o_zero,
   output logic              o_overflow,
   output logic              o_underflow
);
   state_t state, state_nxt;

   logic [MANT_W:0]   mant_q;
   logic [EXP_W-1:0]  exp_q;
   logic              sign_q;
   logic [4:0]        lz_q, lz;
   logic              zero_q, lz_zero;

   logic [EXP_W:0]    exp_inc;
   logic [EXP_W-1:0]  exp_dec;
   logic [4:0]        sh_amt;
   logic [FRAC_W-1:0] shl;
   logic [FRAC_W-1:0] res_frac;
   logic [EXP_W-1:0]  res_exp;
   logic              res_zero, res_ovf, res_unf;

   LOPD_24bit u_lopd (
      .a    (mant_q[MANT_W-1:0]),
      .lz   (lz),
      .zero (lz_zero)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (i_valid) state_nxt = S_DETECT;
         S_DETECT: state_nxt = S_SHIFT;
         S_SHIFT:  state_nxt = S_OUT;
         S_OUT:    if (i_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (i_flush) state_nxt = S_IDLE;
   end

   assign o_ready = (state == S_IDLE);
   assign o_valid = (state == S_OUT);

   // Priority: carry, zero, normal shift, partial shift into subnormal, exp==0.
   always_comb begin
      exp_inc  = {1'b0, exp_q} + 9'd1;
      exp_dec  = exp_q - {3'b0, lz_q};
      sh_amt   = '0;
      res_frac = '0;
      res_exp  = '0;
      res_zero = 1'b0;
      res_ovf  = 1'b0;
      res_unf  = 1'b0;
      if (mant_q[MANT_W]) begin
         if (exp_inc >= {1'b0, EXP_MAX}) begin
            res_exp = EXP_MAX;
            res_ovf = 1'b1;
         end else begin
            res_frac = mant_q[MANT_W-1:1];
            res_exp  = exp_inc[EXP_W-1:0];
         end
      end else if (zero_q) begin
         res_zero = 1'b1;
      end else if ({3'b0, lz_q} < exp_q) begin
         sh_amt  = lz_q;
         res_exp = exp_dec;
      end else if (exp_q != '0) begin
         sh_amt  = exp_q[4:0] - 5'd1;
         res_unf = 1'b1;
      end else begin
         res_unf = 1'b1;
      end
      // Hidden bit falls off the top of the 23-bit shift result.
      shl = mant_q[FRAC_W-1:0] << sh_amt;
      if (!mant_q[MANT_W] && !zero_q) res_frac = shl;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mant_q      <= '0;
         exp_q       <= '0;
         sign_q      <= 1'b0;
         lz_q        <= LZC_ZERO;
         zero_q      <= 1'b0;
         o_frac      <= '0;
         o_exp       <= '0;
         o_sign      <= 1'b0;
         o_zero      <= 1'b0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (state == S_IDLE && i_valid && !i_flush) begin
            mant_q <= i_mant;
            exp_q  <= i_exp;
            sign_q <= i_sign;
         end
         if (state == S_DETECT) begin
            lz_q   <= lz;
            zero_q <= lz_zero;
         end
         if (i_flush) begin
            o_zero      <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
         end else if (state == S_SHIFT) begin
            o_frac      <= res_frac;
            o_exp       <= res_exp;
            o_sign      <= sign_q;
            o_zero      <= res_zero;
            o_overflow  <= res_ovf;
            o_underflow <= res_unf;
         end
      end
   end
endmodule

// File: tb/tb_fp_norm_ctrl.sv
// Randomized and directed bench for fp_norm_ctrl against a behavioural normalizer.
module tb_fp_norm_ctrl;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [24:0] i_mant = '0;
   logic [7:0]  i_exp = '0;
   logic        i_sign = 1'b0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [22:0] o_frac;
   logic [7:0]  o_exp;
   logic        o_sign, o_zero, o_overflow, o_underflow;

   int n_vec = 0;
   int n_err = 0;

   fp_norm_ctrl dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_mant(i_mant), .i_exp(i_exp), .i_sign(i_sign), .i_flush(i_flush),
      .o_valid(o_valid), .i_ready(i_ready), .o_frac(o_frac), .o_exp(o_exp),
      .o_sign(o_sign), .o_zero(o_zero), .o_overflow(o_overflow),
      .o_underflow(o_underflow)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [34:0] pk(input logic s, input logic z, input logic o,
                                      input logic u, input logic [7:0] e, input logic [22:0] f);
      return {s, z, o, u, e, f};
   endfunction

   function automatic logic [34:0] obs();
      return {o_sign, o_zero, o_overflow, o_underflow, o_exp, o_frac};
   endfunction

   // Normalize by shifting one place at a time while the exponent can absorb it.
   function automatic logic [34:0] model(input logic [24:0] m, input logic [7:0] e, input logic s);
      int ex;
      logic [23:0] f;
      if (m[24]) begin
         ex = int'(e) + 1;
         if (ex >= 255) return pk(s, 1'b0, 1'b1, 1'b0, 8'hFF, 23'd0);
         return pk(s, 1'b0, 1'b0, 1'b0, 8'(ex), m[23:1]);
      end
      if (m[23:0] == 24'd0) return pk(s, 1'b1, 1'b0, 1'b0, 8'd0, 23'd0);
      f  = m[23:0];
      ex = int'(e);
      if (ex == 0) return pk(s, 1'b0, 1'b0, 1'b1, 8'd0, f[22:0]);
      while (!f[23] && ex > 1) begin
         f = f << 1;
         ex--;
      end
      if (f[23]) return pk(s, 1'b0, 1'b0, 1'b0, 8'(ex), f[22:0]);
      return pk(s, 1'b0, 1'b0, 1'b1, 8'd0, f[22:0]);
   endfunction

   // Called at a negedge with the block idle; returns at a negedge after the handshake.
   task automatic apply(input logic [24:0] m, input logic [7:0] e, input logic s,
                        input int hold, input logic [34:0] want);
      chk("ready_idle", 64'(o_ready), 64'd1);
      i_mant = m; i_exp = e; i_sign = s; i_valid = 1'b1; i_ready = 1'b0;
      @(posedge i_clk); #1 i_valid = 1'b0;
      @(negedge i_clk); chk("lat_detect_valid", 64'(o_valid), 64'd0);
      @(negedge i_clk); chk("lat_shift_valid", 64'(o_valid), 64'd0);
      @(negedge i_clk);
      chk("out_valid", 64'(o_valid), 64'd1);
      chk("out_not_ready", 64'(o_ready), 64'd0);
      chk("result", 64'(obs()), 64'(want));
      for (int k = 0; k < hold; k++) begin
         @(negedge i_clk);
         chk("hold_valid", 64'(o_valid), 64'd1);
         chk("hold_ready", 64'(o_ready), 64'd0);
         chk("hold_result", 64'(obs()), 64'(want));
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
      chk("post_hs_valid", 64'(o_valid), 64'd0);
      chk("post_hs_ready", 64'(o_ready), 64'd1);
   endtask

   initial begin
      logic [24:0] m, mask;
      logic [7:0]  e;
      logic        s;
      int          w;

      #23 i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_outputs", 64'(obs()), 64'd0);

      apply(25'h0400000, 8'd100, 1'b0, 0, pk(1'b0, 1'b0, 1'b0, 1'b0, 8'd99, 23'd0));
      apply(25'h1800000, 8'd127, 1'b1, 0, pk(1'b1, 1'b0, 1'b0, 1'b0, 8'd128, 23'h400000));
      apply(25'h1000000, 8'd254, 1'b0, 0, pk(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 23'd0));
      apply(25'h0000000, 8'd50,  1'b1, 0, pk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 23'd0));
      apply(25'h0000100, 8'd5,   1'b0, 0, pk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 23'h001000));
      apply(25'h0000100, 8'd0,   1'b0, 0, pk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 23'h000100));
      apply(25'h0000100, 8'd16,  1'b0, 0, pk(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 23'd0));
      apply(25'h0C00000, 8'd42,  1'b1, 5, model(25'h0C00000, 8'd42, 1'b1));

      // Flush while the result is being computed: nothing may be emitted.
      i_mant = 25'h0000003; i_exp = 8'd2; i_valid = 1'b1;
      @(posedge i_clk); #1 i_valid = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk); i_flush = 1'b1;
      @(negedge i_clk); i_flush = 1'b0;
      chk("flush_ready", 64'(o_ready), 64'd1);
      chk("flush_valid", 64'(o_valid), 64'd0);
      chk("flush_flags", 64'({o_zero, o_overflow, o_underflow}), 64'd0);
      repeat (3) begin
         @(negedge i_clk);
         chk("flush_no_emit", 64'(o_valid), 64'd0);
      end

      // Flush alongside valid in idle: operand must not be taken.
      i_mant = 25'h0800000; i_exp = 8'd10; i_valid = 1'b1; i_flush = 1'b1;
      @(negedge i_clk); i_valid = 1'b0; i_flush = 1'b0;
      chk("idle_flush_ready", 64'(o_ready), 64'd1);
      repeat (3) begin
         @(negedge i_clk);
         chk("idle_flush_no_emit", 64'(o_valid), 64'd0);
      end

      // Async reset pulse while detecting.
      i_mant = 25'h0400000; i_exp = 8'd77; i_valid = 1'b1;
      @(posedge i_clk); #1 i_valid = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      chk("arst_ready", 64'(o_ready), 64'd1);
      chk("arst_valid", 64'(o_valid), 64'd0);
      chk("arst_outputs", 64'(obs()), 64'd0);
      #1 i_rst_n = 1'b1;
      @(negedge i_clk);
      apply(25'h0200000, 8'd30, 1'b1, 0, pk(1'b1, 1'b0, 1'b0, 1'b0, 8'd28, 23'd0));

      for (int n = 0; n < 60; n++) begin
         s = 1'($urandom);
         case ($urandom_range(0, 4))
            0: begin
               m = {1'b1, 24'($urandom)};
               e = 8'($urandom_range(0, 254));
            end
            1: begin
               m = '0;
               e = 8'($urandom);
            end
            default: begin
               w    = $urandom_range(1, 24);
               mask = (25'd1 << w) - 25'd1;
               m    = 25'($urandom) & mask;
               e    = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 26)) : 8'($urandom);
            end
         endcase
         apply(m, e, s, $urandom_range(0, 2), model(m, e, s));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
